// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and constants for the register-dump UART transmitter.
package regdump_pkg;
    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        CAPTURE,
        SEND_WORD,
        TRAILER,
        FINISH
    } state_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 133;
    localparam int UART_BITS = 10;
endpackage

// File: rtl/regdump_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter with one idle-high cycle after every stop bit.
// Ports: clk, reset (sync, active low); data/valid/ready byte handshake, a byte is
// taken when valid && ready; tx serial line, idles high.
module uart_tx_byte
    import regdump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(UART_BITS - 1);

    logic          active_q, active_d, tx_q, tx_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;

    // ready drops for the 10 bit times and returns in the gap cycle after the stop bit
    assign ready = !active_q;
    assign tx    = tx_q;

    always_comb begin
        active_d = active_q;
        tx_d     = tx_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (!active_q) begin
            if (valid) begin
                active_d = 1'b1;
                tx_d     = 1'b0;
                baud_d   = '0;
                bit_d    = '0;
                shift_d  = {1'b1, data};
            end
        end else if (baud_q != BAUD_LAST) begin
            baud_d = baud_q + 1'b1;
        end else begin
            baud_d = '0;
            if (bit_q == BIT_LAST) begin
                active_d = 1'b0;
                tx_d     = 1'b1;
            end else begin
                // the stop bit sits at the top of the shifter and reaches bit 0 last
                bit_d   = bit_q + 1'b1;
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[8:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            active_q <= active_d;
            tx_q     <= tx_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end
endmodule

// File: rtl/regdump_uart_tx.sv
// regdump_uart_tx: after halt, streams header, all registers and the cycle snapshot over UART.
// Ports: clk, reset (sync, active low); start halt pulse; cycle_count snapshotted on start;
// rf_raddr/rf_rdata spare register-file read port; tx serial line; busy while dumping;
// done one-cycle pulse at frame end.
module regdump_uart_tx
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         NUM_REGS     = 32,
    parameter int         XLEN         = 32,
    parameter logic [7:0] HEADER_BYTE  = regdump_pkg::HEADER_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cycle_count,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    import regdump_pkg::*;

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [4:0]  raddr_q, raddr_d;
    logic [2:0]  byte_q, byte_d;
    logic [31:0] word_q, word_d, cyc_q, cyc_d;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    assign rf_raddr = raddr_q;
    assign busy     = state_q != IDLE && state_q != FINISH;
    assign done     = state_q == FINISH;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .data  (tx_data),
        .valid (tx_valid),
        .ready (tx_ready),
        .tx    (tx)
    );

    // Moving on as soon as a byte is accepted lets FETCH/CAPTURE run while that byte
    // is still on the line, so the next word is ready by the gap cycle.
    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        byte_d   = byte_q;
        word_d   = word_q;
        cyc_d    = cyc_q;
        tx_valid = 1'b0;
        tx_data  = HEADER_BYTE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HEADER;
                    cyc_d   = cycle_count;
                end
            end
            HEADER: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = FETCH;
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                word_d  = rf_rdata;
                state_d = SEND_WORD;
            end
            SEND_WORD: begin
                tx_valid = 1'b1;
                tx_data  = word_q[{byte_q[1:0], 3'b000} +: 8];
                if (tx_ready) begin
                    byte_d = byte_q + 3'd1;
                    if (byte_q == 3'd3) begin
                        byte_d = '0;
                        if (raddr_q == LAST_REG) begin
                            state_d = TRAILER;
                        end else begin
                            raddr_d = raddr_q + 5'd1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            TRAILER: begin
                // byte_q==4 means all four sent; wait for the last one to drain
                tx_valid = byte_q != 3'd4;
                tx_data  = cyc_q[{byte_q[1:0], 3'b000} +: 8];
                if (tx_ready) begin
                    if (byte_q == 3'd4) begin
                        byte_d  = '0;
                        raddr_d = '0;
                        state_d = FINISH;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            raddr_q <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            cyc_q   <= cyc_d;
        end
    end
endmodule

// File: tb/tb_regdump_uart_tx.sv
// tb_regdump_uart_tx: directed self-checking bench for regdump_uart_tx with CLKS_PER_BIT=4.
module tb_regdump_uart_tx;
    import regdump_pkg::*;

    localparam int CPB  = 4;
    localparam int SLOT = 10 * CPB + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cycle_count = '0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        tx, busy, done;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [FRAME_BYTES];
    logic [7:0]  got_q [FRAME_BYTES];
    int vectors = 0;
    int errors = 0;

    assign rf_rdata = regs[rf_raddr];

    always #5 clk = ~clk;

    regdump_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cycle_count (cycle_count),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input logic [31:0] cyc, input logic [31:0] r31);
        logic [31:0] v;
        exp_q[0] = 8'hA5;
        for (int r = 0; r < 32; r++) begin
            v = (r == 31) ? r31 : regs[r];
            for (int b = 0; b < 4; b++) exp_q[1 + 4 * r + b] = v[8 * b +: 8];
        end
        for (int b = 0; b < 4; b++) exp_q[129 + b] = cyc[8 * b +: 8];
    endtask

    // Walks the expected line waveform cycle by cycle: one comparison per byte slot.
    task automatic run_frame(input logic [31:0] cyc, input int poke_at, input int abort_at,
                             input int snap_at, input logic [31:0] new_cyc,
                             input logic [31:0] new_r31);
        int done_early;
        logic [7:0] g, eb;
        logic mism, s, e;
        done_early = 0;
        @(negedge clk);
        cycle_count = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_tx", {31'd0, tx}, 32'd1);
        for (int k = 0; k < FRAME_BYTES; k++) begin
            mism = 1'b0;
            g = '0;
            eb = exp_q[k];
            for (int j = 0; j < SLOT; j++) begin
                @(negedge clk);
                s = tx;
                e = (j < CPB) ? 1'b0 : (j < 9 * CPB) ? eb[(j - CPB) / CPB] : 1'b1;
                if (s !== e) mism = 1'b1;
                if (j >= CPB && j < 9 * CPB && (j % CPB) == CPB / 2) g[(j - CPB) / CPB] = s;
                if (done) done_early++;
                if (k == snap_at && j == 0) begin
                    cycle_count = new_cyc;
                    regs[31] = new_r31;
                end
                if (k == poke_at) start = (j == 0);
                if (k == abort_at && j == 5) begin
                    reset = 1'b0;
                    @(negedge clk);
                    chk("abort_tx", {31'd0, tx}, 32'd1);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_raddr", {27'd0, rf_raddr}, 32'd0);
                    reset = 1'b1;
                    return;
                end
            end
            got_q[k] = g;
            vectors++;
            assert (!mism) else begin
                errors++;
                $error("FAIL byte%0d observed=%h expected=%h", k, g, eb);
            end
        end
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_early", done_early, 32'd0);
        chk("finish_busy", {31'd0, busy}, 32'd0);
        chk("finish_raddr", {27'd0, rf_raddr}, 32'd0);
        @(negedge clk);
        chk("done_once", {31'd0, done}, 32'd0);
        chk("idle_tx", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'((r << 24) | r);
        repeat (3) begin
            @(negedge clk);
            chk("reset_state", {24'd0, tx, busy, done, rf_raddr}, {24'd0, 8'b100_00000});
        end
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_state", {24'd0, tx, busy, done, rf_raddr}, {24'd0, 8'b100_00000});
        end

        build_exp(32'd1234, regs[31]);
        run_frame(32'd1234, -1, -1, -1, 32'd0, 32'd0);
        chk("hdr", {24'd0, got_q[0]}, 32'h0000_00A5);
        chk("r5_b0", {24'd0, got_q[21]}, 32'h0000_0005);
        chk("r5_b1", {24'd0, got_q[22]}, 32'h0000_0000);
        chk("r5_b2", {24'd0, got_q[23]}, 32'h0000_0000);
        chk("r5_b3", {24'd0, got_q[24]}, 32'h0000_0005);
        chk("cyc_b0", {24'd0, got_q[129]}, 32'h0000_00D2);
        chk("cyc_b1", {24'd0, got_q[130]}, 32'h0000_0004);
        chk("cyc_b2", {24'd0, got_q[131]}, 32'h0000_0000);
        chk("cyc_b3", {24'd0, got_q[132]}, 32'h0000_0000);

        run_frame(32'd1234, 10, -1, -1, 32'd0, 32'd0);

        run_frame(32'd1234, -1, 40, -1, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("post_abort", {24'd0, tx, busy, done, rf_raddr}, {24'd0, 8'b100_00000});
        build_exp(32'h0000_0309, regs[31]);
        run_frame(32'h0000_0309, -1, -1, -1, 32'd0, 32'd0);

        build_exp(32'h0BAD_F00D, 32'hDEAD_BEEF);
        run_frame(32'h0BAD_F00D, -1, -1, 0, 32'h1111_1111, 32'hDEAD_BEEF);
        chk("snap_cyc", {got_q[132], got_q[131], got_q[130], got_q[129]}, 32'h0BAD_F00D);
        chk("snap_r31", {got_q[128], got_q[127], got_q[126], got_q[125]}, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
